// File: rtl/mxbus_pkg.sv
// Shared widths, depth and FSM state encoding for the mxbus write target.
package mxbus_pkg;

  localparam int ADDR_W = 6;
  localparam int LEN_W  = 6;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int DEPTH  = 64;
  localparam int CNT_W  = 7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_DATA     = 2'd2
  } state_t;

  // A length field of zero stands for a full-depth burst.
  function automatic logic [CNT_W-1:0] decode_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? CNT_W'(DEPTH) : {1'b0, len};
  endfunction

endpackage

// File: rtl/mxbus_if.sv
// Burst write bus plus consumer read port between a master and the mxbus target.
interface mxbus_if;
  import mxbus_pkg::*;

  logic              start;
  logic              ready;
  logic [ADDR_W-1:0] address;
  logic [LEN_W-1:0]  length;
  logic              dvalid;
  logic [DATA_W-1:0] data;
  logic [STRB_W-1:0] strobe;
  logic              complete;
  logic              ack;
  logic              xfer_done;
  logic              err;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output start, ready, address, length, dvalid, data, strobe, complete, rd_addr,
    input  ack, xfer_done, err, rd_data
  );

  modport slave (
    input  start, ready, address, length, dvalid, data, strobe, complete, rd_addr,
    output ack, xfer_done, err, rd_data
  );

endinterface

// File: rtl/mxbus_mem.sv
// 64x32 storage with per-byte write enables and a registered read port.
module mxbus_mem
  import mxbus_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array is deliberately left without reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mxbus_target.sv
// Burst write target: accepts a request, counts beats into storage, flags protocol errors.
//
//   state       | meaning
//   ST_IDLE     | waiting for start; latches address/length and clears err
//   ST_WAIT_RDY | request latched, waiting for master ready; ack on accept
//   ST_DATA     | accepting beats until complete
module mxbus_target
  import mxbus_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  mxbus_if.slave  bus
);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  len_q;
  logic              xfer_done_q;
  logic              err_q;
  logic              beat_ok;
  logic [CNT_W-1:0]  cnt_next;

  assign beat_ok  = (state == ST_DATA) && bus.dvalid && (beat_cnt < len_q);
  assign cnt_next = beat_cnt + CNT_W'(beat_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      beat_cnt    <= '0;
      len_q       <= '0;
      xfer_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      xfer_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            wr_ptr   <= bus.address;
            len_q    <= decode_len(bus.length);
            beat_cnt <= '0;
            err_q    <= 1'b0;
            state    <= ST_WAIT_RDY;
          end
        end
        ST_WAIT_RDY: begin
          if (bus.ready) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat_ok) begin
            wr_ptr   <= wr_ptr + 1'b1;
            beat_cnt <= cnt_next;
          end
          // A beat arriving with complete counts toward the final tally.
          if (bus.complete) begin
            if (cnt_next == len_q) begin
              xfer_done_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Any beat not written (outside DATA or past len) is an error, even on the accepting cycle.
      if (bus.dvalid && !beat_ok) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.ack       = (state == ST_WAIT_RDY) && bus.ready;
  assign bus.xfer_done = xfer_done_q;
  assign bus.err       = err_q;

  mxbus_mem u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (beat_ok),
    .waddr (wr_ptr),
    .wdata (bus.data),
    .wstrb (bus.strobe),
    .raddr (bus.rd_addr),
    .rdata (bus.rd_data)
  );

endmodule

// File: doc/mxbus_target.md
MXBUS_TARGET -- requirements
Module: mxbus_target

Interface
REQ-001 Parameters: none; widths come from mxbus_pkg (ADDR_W=6, LEN_W=6, DATA_W=32, STRB_W=4, DEPTH=64).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low, synchronous release.
REQ-004 start  input  1  master request strobe; address/length are valid in the same cycle.
REQ-005 ready  input  1  master ready to begin the data phase.
REQ-006 address  input  6  first word address of the burst.
REQ-007 length  input  6  beat count; 0 encodes 64.
REQ-008 dvalid  input  1  data beat valid.
REQ-009 data  input  32  beat payload.
REQ-010 strobe  input  4  byte enables; strobe[i] qualifies data[8i+7:8i].
REQ-011 complete  input  1  master end-of-burst marker.
REQ-012 ack  output  1  request accepted, single-cycle pulse.
REQ-013 xfer_done  output  1  single-cycle pulse on a correctly terminated burst.
REQ-014 err  output  1  sticky protocol-error flag.
REQ-015 rd_addr  input  6  consumer read address.
REQ-016 rd_data  output  32  registered read data, one-cycle latency.

Function
REQ-017 FSM states: IDLE, WAIT_RDY, DATA.
REQ-018 IDLE with start=1: latch address into wr_ptr, length into len_q, clear beat_cnt and err, go to WAIT_RDY.
REQ-019 WAIT_RDY with ready=1: drive ack=1 for exactly that cycle, go to DATA; while ready=0, stay in WAIT_RDY with ack=0.
REQ-020 start is ignored in WAIT_RDY and DATA.
REQ-021 In DATA with dvalid=1 and beat_cnt<len: write each byte lane of data whose strobe bit is 1 to mem[wr_ptr], leave lanes with strobe=0 unchanged, increment wr_ptr modulo 64 (63 wraps to 0), increment beat_cnt.
REQ-022 In DATA with dvalid=1 and beat_cnt already equal to len: discard the beat without writing and set err.
REQ-023 dvalid outside DATA: discard the beat and set err.
REQ-024 In DATA with complete=1, first count any same-cycle beat, then compare the count: if it equals len, pulse xfer_done next cycle; otherwise set err. Return to IDLE in both cases.
REQ-025 beat_cnt is 7 bits wide so that it can hold 64; len_q = (length==0) ? 64 : length.
REQ-026 rd_data <= mem[rd_addr] every cycle. Reads and writes to the same address in the same cycle return the old data.
REQ-027 err stays set until the next start is accepted in IDLE.

Reset
REQ-028 On rst_n=0, the FSM goes to IDLE and ack=0, xfer_done=0, err=0, rd_data=0, wr_ptr=0, beat_cnt=0, len_q=0; memory contents are not reset.
REQ-029 Reset asserted mid-burst aborts the burst with no xfer_done pulse; beats already written stay in memory.

Structure
REQ-030 mxbus_pkg holds the width/depth constants and the state enum typedef.
REQ-031 Storage is a sub-module mxbus_mem: a 64x32 array with byte-enable write and a registered read port. mxbus_target contains only the FSM and the pointer and counter logic.

Verification
REQ-032 start, address=5, length=3, then ready, then 3 beats of 0xA0..0xA2 with strobe=0xF, then complete -> one ack pulse, mem[5..7]=0xA0..0xA2, one xfer_done pulse, err=0.
REQ-033 address=62, length=4 -> writes go to 62, 63, 0, 1 (wrap-around), then xfer_done.
REQ-034 length=0 with 64 beats, complete on the last beat -> all 64 words written, xfer_done=1.
REQ-035 Preload 0xFFFFFFFF, then write 0x12345678 with strobe=0x5 -> read gives 0xFF34FF78 on the cycle after rd_addr is applied.
REQ-036 length=2 with complete after 1 beat -> err=1, no xfer_done; a 3rd beat on a length=2 burst -> discarded, err=1; the next accepted start clears err.
REQ-037 rst_n pulsed low after 2 of 4 beats -> FSM in IDLE, outputs zero, the 2 written words retained, no xfer_done.
